// File: rtl/segled_pkg.sv
// Shared definitions for the multiplexed 7-segment display controller.
// Holds segment patterns (bit0..6 = a..g), the converter FSM state type and
// a helper that sizes the BCD register for a given binary width.
package segled_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } conv_state_e;

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // BCD digits needed for a data_w-bit value: ceil(data_w*log10(2)) + 1.
  function automatic int nbcd_f(input int data_w);
    return (data_w * 30103 + 99999) / 100000 + 1;
  endfunction

  function automatic logic [6:0] seg7_f(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/segled_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Latency: start accepted in IDLE, DATA_W cycles CONV, 1 cycle DONE (done_o).
// Backpressure: busy_o high in CONV/DONE; start_i ignored unless IDLE.
// Ports: sys_clk/sys_rst_n; start_i + bin_i load; busy_o, done_o, bcd_o result.
module segled_bcd_seq
  import segled_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NBCD   = nbcd_f(DATA_W)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] bin_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [4*NBCD-1:0] bcd_o
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  conv_state_e              state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [DATA_W-1:0]        bin_q;
  logic [4*NBCD-1:0]        bcd_q, bcd_adj;
  logic [4*NBCD+DATA_W-1:0] shift_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_CONV;
      ST_CONV: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != ST_IDLE);
    done_o = (state_q == ST_DONE);
  end

  // Add 3 to every digit >= 5 before the shift so it carries correctly.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shift_d = {bcd_adj, bin_q} << 1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (state_q == ST_IDLE && start_i) begin
      cnt_q <= '0;
      bin_q <= bin_i;
      bcd_q <= '0;
    end else if (state_q == ST_CONV) begin
      {bcd_q, bin_q} <= shift_d;
      cnt_q          <= cnt_q + CNT_W'(1);
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/segled_scan_ctrl.sv
// Multiplexed 7-segment display controller: converts a binary value to BCD and scans it out.
// Latency: handshake -> display register updated DATA_W+1 cycles later; seg/seg_sel 1 cycle after scan index.
// Backpressure: in_ready low while converting; in_valid during that time is ignored, nothing queued.
// Ports: in_data/in_valid/in_ready/signed_mode load; blank_lz, dp_mask live controls;
//        seg_sel (one-hot digit), seg (a..g, dp), overflow.
module segled_scan_ctrl
  import segled_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DATA_W     = 32,
  parameter int SCAN_DIV   = 16384,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              signed_mode,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [DIGITS-1:0] seg_sel,
  output logic [7:0]        seg,
  output logic              overflow
);

  localparam int NBCD   = nbcd_f(DATA_W);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
  localparam logic              POL_LOW   = (ACTIVE_LOW != 0);

  logic                        busy, done, start, neg_in;
  logic [DATA_W-1:0]           mag;
  logic [4*NBCD-1:0]           bcd;
  logic [4*(NBCD+DIGITS)-1:0]  bcd_ext;
  logic                        ovf_c;
  logic                        neg_pend_q;
  logic [4*DIGITS-1:0]         disp_q;
  logic                        neg_q, ovf_q;
  logic [SCAN_W-1:0]           scan_cnt_q;
  logic [DIG_W-1:0]            dig_q;
  logic [4*DIGITS+3:0]         from_prev, cur_vec;
  logic                        upper_zero, prev_upper_zero, minus_here;
  logic [6:0]                  pat;
  logic [7:0]                  seg_d, seg_q;
  logic [DIGITS-1:0]           sel_d, sel_q;

  assign in_ready = ~busy;
  assign start    = in_valid & ~busy;
  assign neg_in   = signed_mode & in_data[DATA_W-1];
  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign mag      = neg_in ? ((~in_data) + DATA_W'(1)) : in_data;

  segled_bcd_seq #(.DATA_W(DATA_W), .NBCD(NBCD)) u_bcd (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .start_i  (start),
    .bin_i    (mag),
    .busy_o   (busy),
    .done_o   (done),
    .bcd_o    (bcd)
  );

  // Zero-extend so digits beyond NBCD read as 0 when DIGITS > NBCD.
  assign bcd_ext = {{(4*DIGITS){1'b0}}, bcd};

  // Negative values reserve the top digit for the minus sign.
  always_comb begin
    ovf_c = 1'b0;
    for (int i = 0; i < NBCD; i++) begin
      if (bcd[4*i +: 4] != 4'd0 && (i >= DIGITS || (neg_pend_q && i >= DIGITS - 1)))
        ovf_c = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      neg_pend_q <= 1'b0;
      disp_q     <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (start) neg_pend_q <= neg_in;
      if (done) begin
        disp_q <= bcd_ext[4*DIGITS-1:0];
        neg_q  <= neg_pend_q;
        ovf_q  <= ovf_c;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scan_cnt_q <= '0;
      dig_q      <= '0;
    end else if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_q <= '0;
      dig_q      <= (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
    end else begin
      scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
    end
  end

  // from_prev puts digit dig_q-1 in its low nibble (0 for dig_q = 0), so
  // "this digit and above all zero" and the minus slot (directly above the
  // most significant nonzero digit) fall out of two zero tests.
  always_comb begin
    from_prev       = {disp_q, 4'h0} >> (4 * int'(dig_q));
    cur_vec         = from_prev >> 4;
    upper_zero      = (cur_vec == '0);
    prev_upper_zero = (from_prev == '0);
    minus_here      = blank_lz ? (upper_zero && !prev_upper_zero) : (dig_q == DIG_LAST);

    if (ovf_q)                                  pat = SEG_MINUS;
    else if (neg_q && minus_here)               pat = SEG_MINUS;
    else if (blank_lz && upper_zero && dig_q != '0) pat = SEG_BLANK;
    else                                        pat = seg7_f(cur_vec[3:0]);

    seg_d = {dp_mask[dig_q], pat};
    sel_d = DIGITS'(1) << dig_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_q <= POL_LOW ? 8'hFF : 8'h00;
      sel_q <= POL_LOW ? '1 : '0;
    end else begin
      seg_q <= POL_LOW ? ~seg_d : seg_d;
      sel_q <= POL_LOW ? ~sel_d : sel_d;
    end
  end

  assign seg      = seg_q;
  assign seg_sel  = sel_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_segled_scan_ctrl.sv
// Directed bench for segled_scan_ctrl with DIGITS=4, DATA_W=32, SCAN_DIV=4, active-low pins.
// Expected segment bytes come from the bench's own pattern table.
module tb_segled_scan_ctrl;

  logic        sys_clk, sys_rst_n;
  logic [31:0] in_data;
  logic        in_valid, in_ready, signed_mode, blank_lz;
  logic [3:0]  dp_mask, seg_sel;
  logic [7:0]  seg;
  logic        overflow;

  segled_scan_ctrl #(.DIGITS(4), .DATA_W(32), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_mode(signed_mode),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .seg_sel    (seg_sel),
    .seg        (seg),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [7:0] BL = 8'hFF;  // blank, no dp
  localparam logic [7:0] MN = 8'hBF;  // minus (g only), no dp

  int         n_chk, n_pass, mon_bad;
  logic       mon_en;
  logic [7:0] frame [4];

  function automatic logic [7:0] es(input logic [6:0] p, input logic dp);
    return ~{dp, p};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Digit 0 may only ever show 9 (old), 7 or 6 during the 7 -> 56 sequence.
  always @(negedge sys_clk) begin
    if (mon_en && seg_sel == 4'b1110 &&
        seg != es(PAT[9], 1'b0) && seg != es(PAT[7], 1'b0) && seg != es(PAT[6], 1'b0))
      mon_bad++;
  end

  task automatic send(input string tag, input logic [31:0] v, input logic sm);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge sys_clk); #1; n++; end
    in_data = v; signed_mode = sm; in_valid = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 200) begin @(posedge sys_clk); #1; n++; end
    chk({tag, "_ready_low"}, n, 33);
  endtask

  task automatic capture();
    for (int k = 0; k < 4; k++) frame[k] = 8'h00;
    repeat (2) @(posedge sys_clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge sys_clk);
      case (seg_sel)
        4'b1110: frame[0] = seg;
        4'b1101: frame[1] = seg;
        4'b1011: frame[2] = seg;
        4'b0111: frame[3] = seg;
        default: ;
      endcase
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                           input logic [7:0] e1, input logic [7:0] e0);
    capture();
    chk({tag, "_d3"}, frame[3], e3);
    chk({tag, "_d2"}, frame[2], e2);
    chk({tag, "_d1"}, frame[1], e1);
    chk({tag, "_d0"}, frame[0], e0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev_sel, exp_sel;
    logic       found;
    int         n;
    sys_clk = 0; sys_rst_n = 0; in_valid = 0; in_data = 0; signed_mode = 0;
    blank_lz = 1; dp_mask = 0; mon_en = 0; mon_bad = 0; n_chk = 0; n_pass = 0;

    // Reset state
    repeat (3) @(posedge sys_clk); #1;
    chk("rst_seg", seg, 8'hFF);
    chk("rst_sel", seg_sel, 4'hF);
    sys_rst_n = 1;
    @(posedge sys_clk); #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_ovf", overflow, 0);
    chk_frame("rst", BL, BL, BL, es(PAT[0], 0));

    // 1234 unsigned
    send("u1234", 32'd1234, 1'b0);
    chk("u1234_ovf", overflow, 0);
    chk_frame("u1234", es(PAT[1], 0), es(PAT[2], 0), es(PAT[3], 0), es(PAT[4], 0));
    prev_sel = seg_sel; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge sys_clk); #1;
      if (seg_sel == 4'b1110 && prev_sel != 4'b1110) found = 1;
      prev_sel = seg_sel;
    end
    chk("sel_sync", found, 1);
    for (int c = 0; c < 16; c++) begin
      exp_sel = 4'b0001 << (c / 4);
      exp_sel = ~exp_sel;
      chk("sel_step", seg_sel, exp_sel);
      @(posedge sys_clk); #1;
    end

    // -42 signed, dp on digit 1
    dp_mask = 4'b0010;
    send("neg42", 32'hFFFFFFD6, 1'b1);
    chk("neg42_ovf", overflow, 0);
    chk_frame("neg42", BL, MN, es(PAT[4], 1), es(PAT[2], 0));
    dp_mask = 4'b0000;

    // Zero, then live blank_lz toggle
    send("zero", 32'd0, 1'b0);
    chk_frame("zero_lz", BL, BL, BL, es(PAT[0], 0));
    blank_lz = 0;
    chk_frame("zero_nolz", es(PAT[0], 0), es(PAT[0], 0), es(PAT[0], 0), es(PAT[0], 0));
    blank_lz = 1;

    // Overflow cases, then largest fitting value
    send("u10000", 32'd10000, 1'b0);
    chk("u10000_ovf", overflow, 1);
    chk_frame("u10000", MN, MN, MN, MN);
    send("neg1000", 32'hFFFFFC18, 1'b1);
    chk("neg1000_ovf", overflow, 1);
    chk_frame("neg1000", MN, MN, MN, MN);
    send("u9999", 32'd9999, 1'b0);
    chk("u9999_ovf", overflow, 0);
    chk_frame("u9999", es(PAT[9], 0), es(PAT[9], 0), es(PAT[9], 0), es(PAT[9], 0));

    // 7 then 56 held from cycle 5 of the first conversion
    mon_en = 1;
    in_data = 32'd7; signed_mode = 0; in_valid = 1;
    @(posedge sys_clk); #1;
    in_valid = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 4) begin in_valid = 1; in_data = 32'd56; end
      if (in_ready) break;
      n++;
      @(posedge sys_clk); #1;
    end
    chk("hold_ready_low", n, 33);
    chk("hold_valid_held", in_valid, 1);
    @(posedge sys_clk); #1;
    in_valid = 0;
    chk("hold_accepted", in_ready, 0);
    chk_frame("show7", BL, BL, BL, es(PAT[7], 0));
    n = 0;
    while (!in_ready && n < 200) begin @(posedge sys_clk); #1; n++; end
    chk("hold_done", in_ready, 1);
    chk_frame("show56", BL, BL, es(PAT[5], 0), es(PAT[6], 0));
    mon_en = 0;
    chk("no_intermediate", mon_bad, 0);

    // Reset in the middle of a conversion
    in_data = 32'd1234; in_valid = 1;
    @(posedge sys_clk); #1;
    in_valid = 0;
    repeat (9) @(posedge sys_clk);
    #1;
    chk("midrst_busy", in_ready, 0);
    sys_rst_n = 0;
    #1;
    chk("midrst_seg", seg, 8'hFF);
    chk("midrst_sel", seg_sel, 4'hF);
    @(posedge sys_clk); #1;
    sys_rst_n = 1;
    @(posedge sys_clk); #1;
    chk("midrst_ready", in_ready, 1);
    repeat (40) @(posedge sys_clk);
    #1;
    chk("midrst_ready_late", in_ready, 1);
    chk("midrst_ovf", overflow, 0);
    chk_frame("midrst", BL, BL, BL, es(PAT[0], 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/segled_scan_ctrl.md
SEGLED_SCAN_CTRL -- requirements
Module: segled_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits (1..8).
REQ-002 Parameter DATA_W, default 32: input binary width (4..32).
REQ-003 Parameter SCAN_DIV, default 16384: sys_clk cycles each digit stays selected.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 = seg and seg_sel pins active-low, 0 = active-high.
REQ-005 sys_clk  in  1  clock; all logic on rising edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 in_data  in  DATA_W  value to display.
REQ-008 in_valid  in  1  in_data presented.
REQ-009 in_ready  out  1  block can accept a value; transfer when in_valid & in_ready.
REQ-010 signed_mode  in  1  sampled at transfer; 1 = in_data is two's complement.
REQ-011 blank_lz  in  1  live; 1 = blank leading zeros.
REQ-012 dp_mask  in  DIGITS  live; decimal point enable per digit.
REQ-013 seg_sel  out  DIGITS  one-hot digit enable; bit 0 = least significant (rightmost) digit.
REQ-014 seg  out  8  segments: bit0..6 = a..g, bit7 = h (dp).
REQ-015 overflow  out  1  latched value does not fit in DIGITS digits.

Function
REQ-016 Converter FSM states: IDLE, CONV, DONE; in_ready = 1 only in IDLE.
REQ-017 IDLE -> CONV on transfer; magnitude captured as -in_data if signed_mode and MSB = 1, else in_data; sign flag captured.
REQ-018 CONV runs exactly DATA_W cycles of shift-and-add-3 (double dabble) over NBCD = ceil(DATA_W*0.30103)+1 BCD digits, then DONE.
REQ-019 DONE lasts 1 cycle, writes BCD result, sign and overflow into display register, returns to IDLE.
REQ-020 Latency: handshake in cycle 0 -> display register and overflow updated at end of cycle DATA_W+1; in_ready low for DATA_W+1 cycles.
REQ-021 Display register holds previous value throughout CONV; no partial result ever shown.
REQ-022 in_valid while in_ready = 0 is ignored; data is not queued.
REQ-023 overflow = 1 when any BCD digit index >= DIGITS is nonzero (unsigned/positive) or index >= DIGITS-1 is nonzero (negative); signed -2^(DATA_W-1) handled via unsigned magnitude.
REQ-024 On overflow every digit shows minus (g only); dp still per dp_mask.
REQ-025 Scan counter counts 0..SCAN_DIV-1 then wraps; digit index increments on wrap, DIGITS-1 wraps to 0.
REQ-026 Digit i shows BCD digit i with standard 0-9 patterns; codes 10-15 never produced.
REQ-027 blank_lz = 1: digits above the most significant nonzero digit blank; digit 0 always shown (value 0 shows "0").
REQ-028 Negative: minus in the digit directly above most significant nonzero digit when blank_lz = 1, in digit DIGITS-1 when blank_lz = 0.
REQ-029 seg and seg_sel are registered: reflect digit index and display register with 1-cycle latency; polarity per ACTIVE_LOW.

Reset
REQ-030 Asynchronous assert: FSM to IDLE, scan counter and digit index 0, display register 0, sign 0, overflow 0.
REQ-031 During reset seg and seg_sel inactive (all ones when ACTIVE_LOW = 1); in_ready = 1 after release.
REQ-032 Reset mid-CONV aborts conversion; no write to display register.

Structure
REQ-033 Package segled_pkg holds segment pattern constants (digits 0-9, MINUS, BLANK), FSM state typedef and NBCD computation function.
REQ-034 Sub-module segled_bcd_seq implements the iterative converter (start, done, busy, bcd output); top holds scan, blanking, sign placement, output registers.

Verification (DIGITS = 4, DATA_W = 32, SCAN_DIV = 4, ACTIVE_LOW = 1)
REQ-035 Load 1234 unsigned, blank_lz = 1 -> in_ready low 33 cycles; digits 3..0 show 1,2,3,4; seg_sel steps 1110,1101,1011,0111 every 4 cycles.
REQ-036 signed_mode = 1, in_data = 0xFFFFFFD6 (-42), blank_lz = 1 -> digit3 blank, digit2 minus, digit1 '4', digit0 '2'; overflow 0.
REQ-037 Load 0: blank_lz = 1 -> only digit0 '0'; toggle blank_lz = 0 -> "0000" without reload.
REQ-038 Load 10000 unsigned and signed -1000 -> overflow = 1, all four digits minus; then load 9999 -> overflow 0, "9999".
REQ-039 Load 7, hold in_valid with 56 from cycle 5 -> 56 accepted at cycle 33 handshake; display shows 7 then 56, never intermediate.
REQ-040 Assert sys_rst_n = 0 at CONV cycle 10 -> seg/seg_sel inactive immediately, display register 0, in_ready 1 after release.
